ball_tracker_sprite: RTL and testbench

BALL_TRACKER_SPRITE -- requirements
Module: ball_tracker_sprite

---
 rtl/ball_tracker_sprite.sv | 152 +++++++++++++++
 tb/tb_ball_tracker_sprite.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ball_tracker_sprite.sv
// Frequency-driven ball sprite. The vertical position eases toward a clamped
// target once per frame, and a 2-stage pipeline renders the ball's pixels.
module ball_tracker_sprite #(
    parameter int          SPHERE_R     = 16,
    parameter int          X_CENTER     = 656,
    parameter int          Y_BASE       = 228,
    parameter int          Y_MAX        = 700,
    parameter int          FREQ_SHIFT   = 2,
    parameter int          SMOOTH_SHIFT = 2,
    parameter logic [23:0] COLOR        = 24'hFF_FF_FF
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic [10:0] hcount_in,
    input  logic [9:0]  vcount_in,
    input  logic [15:0] freq_in,
    input  logic        freq_valid_in,
    input  logic        new_frame_in,
    input  logic [1:0]  color_mode_in,
    output logic [7:0]  red_out,
    output logic [7:0]  green_out,
    output logic [7:0]  blue_out,
    output logic [10:0] ball_x,
    output logic [9:0]  ball_y
);

    typedef enum logic [1:0] {
        MODE_FIXED     = 2'd0,
        MODE_FREQ      = 2'd1,
        MODE_RING      = 2'd2,
        MODE_FIXED_ALT = 2'd3
    } color_mode_t;

    localparam logic [16:0] YBASE17 = 17'(Y_BASE);
    localparam logic [16:0] YMAX17  = 17'(Y_MAX);
    localparam logic [9:0]  YBASE10 = 10'(Y_BASE);
    localparam logic [9:0]  YMAX10  = 10'(Y_MAX);
    localparam logic [11:0] XC12    = 12'(X_CENTER);
    localparam logic [9:0]  R10     = 10'(SPHERE_R);
    localparam logic [24:0] R_SQ    = 25'(SPHERE_R * SPHERE_R);
    localparam logic [24:0] RING_SQ = 25'((SPHERE_R - 2) * (SPHERE_R - 2));

    logic [9:0]  target;
    logic [9:0]  pos;
    logic [7:0]  last_freq;
    logic [7:0]  color_freq;

    // ---------------- target and smoothing ----------------
    logic [16:0]        target_sum;
    logic [9:0]         target_next;
    logic signed [10:0] d;
    logic signed [10:0] step_raw;
    logic signed [10:0] step;
    logic [9:0]         pos_next;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        target_sum  = YBASE17 + 17'(freq_in >> FREQ_SHIFT);
        target_next = (target_sum > YMAX17) ? YMAX10 : target_sum[9:0];

        d        = $signed({1'b0, target}) - $signed({1'b0, pos});
        step_raw = d >>> SMOOTH_SHIFT;
        step     = step_raw;
        // Small gaps shift to zero; force a unit step so pos always lands on target.
        if (d != 11'sd0 && step_raw == 11'sd0)
            step = d[10] ? -11'sd1 : 11'sd1;
        pos_next = 10'({1'b0, pos} + $unsigned(step));
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            target     <= YBASE10;
            last_freq  <= '0;
            pos        <= YBASE10;
            color_freq <= '0;
            ball_y     <= YBASE10 - R10;
        end else begin
            if (freq_valid_in) begin
                target    <= target_next;
                last_freq <= freq_in[7:0];
            end
            // Old target/last_freq are used here, so a same-cycle sample lands next frame.
            if (new_frame_in) begin
                pos        <= pos_next;
                color_freq <= last_freq;
            end
            ball_y <= pos - R10;
        end
    end

    assign ball_x = 11'(X_CENTER);

    // ---------------- render stage 1 ----------------
    logic signed [11:0] dx_s1;
    logic signed [10:0] dy_s1;
    color_mode_t        mode_s1;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            dx_s1   <= '0;
            dy_s1   <= '0;
            mode_s1 <= MODE_FIXED;
        end else begin
            dx_s1   <= $signed({1'b0, hcount_in} - XC12);
            dy_s1   <= $signed({1'b0, vcount_in} - {1'b0, pos});
            mode_s1 <= color_mode_t'(color_mode_in);
        end
    end

    // ---------------- render stage 2 ----------------
    logic signed [23:0] dx_w;
    logic signed [23:0] dx_sq;
    logic signed [21:0] dy_w;
    logic signed [21:0] dy_sq;
    logic [24:0]        d2;
    logic [23:0]        tint;
    logic [23:0]        rgb_next;

    always_comb begin
        dx_w  = 24'(dx_s1);
        dy_w  = 22'(dy_s1);
        dx_sq = dx_w * dx_w;
        dy_sq = dy_w * dy_w;
        d2    = 25'($unsigned(dx_sq)) + 25'($unsigned(dy_sq));

        tint = {color_freq & 8'hF0,
                (color_freq + 8'd85) & 8'hF0,
                (color_freq + 8'd175) & 8'hF0};

        rgb_next = '0;
        if (d2 <= R_SQ) begin
            case (mode_s1)
                MODE_FREQ: rgb_next = tint;
                MODE_RING: rgb_next = (d2 > RING_SQ)
                                    ? {1'b0, tint[23:17], 1'b0, tint[15:9], 1'b0, tint[7:1]}
                                    : tint;
                default:   rgb_next = COLOR;
            endcase
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            red_out   <= '0;
            green_out <= '0;
            blue_out  <= '0;
        end else begin
            {red_out, green_out, blue_out} <= rgb_next;
        end
    end

endmodule

// File: tb/tb_ball_tracker_sprite.sv
// Self-checking bench for ball_tracker_sprite: directed scenarios plus random
// traffic, all compared against a frame-level arithmetic model.
module tb_ball_tracker_sprite;

    localparam int R      = 16;
    localparam int XC     = 656;
    localparam int YB     = 228;
    localparam int YM     = 700;
    localparam int FDIV   = 4;
    localparam int SDIV   = 4;

    logic        clk_in = 1'b0;
    logic        rst_n_in;
    logic [10:0] hcount_in;
    logic [9:0]  vcount_in;
    logic [15:0] freq_in;
    logic        freq_valid_in;
    logic        new_frame_in;
    logic [1:0]  color_mode_in;
    logic [7:0]  red_out, green_out, blue_out;
    logic [10:0] ball_x;
    logic [9:0]  ball_y;

    int checks = 0;
    int errors = 0;

    // Model state
    int m_target, m_pos, m_lastf, m_cfreq;
    int pend_h, pend_v, pend_pos, pend_mode;
    bit pend_valid;

    ball_tracker_sprite dut (
        .clk_in        (clk_in),
        .rst_n_in      (rst_n_in),
        .hcount_in     (hcount_in),
        .vcount_in     (vcount_in),
        .freq_in       (freq_in),
        .freq_valid_in (freq_valid_in),
        .new_frame_in  (new_frame_in),
        .color_mode_in (color_mode_in),
        .red_out       (red_out),
        .green_out     (green_out),
        .blue_out      (blue_out),
        .ball_x        (ball_x),
        .ball_y        (ball_y)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int target_of(input int f);
        int t;
        t = YB + f / FDIV;
        return (t > YM) ? YM : t;
    endfunction

    function automatic int smooth(input int p, input int t);
        int dd, s;
        dd = t - p;
        s  = (dd >= 0) ? dd / SDIV : -((-dd + SDIV - 1) / SDIV);
        if (s == 0 && dd != 0) s = (dd > 0) ? 1 : -1;
        return p + s;
    endfunction

    function automatic logic [23:0] pix_model(input int h, input int v, input int p,
                                              input int mode, input int cf);
        int dx, dy, d2, r, g, b;
        dx = h - XC;
        dy = v - p;
        d2 = dx * dx + dy * dy;
        if (d2 > R * R) return 24'h0;
        if (mode == 1 || mode == 2) begin
            r = cf & 240;
            g = ((cf + 85) % 256) & 240;
            b = ((cf + 175) % 256) & 240;
            if (mode == 2 && d2 > (R - 2) * (R - 2)) begin
                r = r / 2; g = g / 2; b = b / 2;
            end
            return {r[7:0], g[7:0], b[7:0]};
        end
        return 24'hFFFFFF;
    endfunction

    task automatic model_reset();
        m_target   = YB;
        m_pos      = YB;
        m_lastf    = 0;
        m_cfreq    = 0;
        pend_valid = 1'b0;
    endtask

    // One clock: predict, advance, then compare every output.
    task automatic cycle();
        bit          have;
        logic [23:0] exp_rgb;
        int          exp_by, n_pos, n_cf, n_t, n_lf;
        have    = pend_valid;
        exp_rgb = have ? pix_model(pend_h, pend_v, pend_pos, pend_mode, m_cfreq) : 24'h0;
        exp_by  = m_pos - R;
        n_pos = m_pos; n_cf = m_cfreq; n_t = m_target; n_lf = m_lastf;
        if (new_frame_in) begin
            n_pos = smooth(m_pos, m_target);
            n_cf  = m_lastf;
        end
        if (freq_valid_in) begin
            n_t  = target_of(int'(freq_in));
            n_lf = int'(freq_in[7:0]);
        end
        pend_h = int'(hcount_in); pend_v = int'(vcount_in);
        pend_pos = m_pos; pend_mode = int'(color_mode_in);
        @(posedge clk_in);
        #1;
        m_pos = n_pos; m_cfreq = n_cf; m_target = n_t; m_lastf = n_lf;
        pend_valid = 1'b1;
        if (have) check("rgb", {red_out, green_out, blue_out}, exp_rgb);
        check("ball_y", ball_y, exp_by);
        check("ball_x", ball_x, XC);
    endtask

    task automatic frame();
        new_frame_in = 1'b1;
        cycle();
        new_frame_in = 1'b0;
        cycle();
    endtask

    task automatic pulse_freq(input logic [15:0] f);
        freq_in       = f;
        freq_valid_in = 1'b1;
        cycle();
        freq_valid_in = 1'b0;
    endtask

    initial begin
        rst_n_in = 1'b0; hcount_in = '0; vcount_in = '0; freq_in = '0;
        freq_valid_in = 1'b0; new_frame_in = 1'b0; color_mode_in = 2'd0;
        model_reset();
        #23;
        check("reset_rgb", {red_out, green_out, blue_out}, 24'h0);
        check("reset_ball_y", ball_y, 212);
        check("ball_x_const", ball_x, XC);
        @(negedge clk_in);
        rst_n_in = 1'b1;
        @(posedge clk_in);
        #1;

        // Pixel test around the resting position
        vcount_in = 10'd228; color_mode_in = 2'd0;
        hcount_in = 11'd656; cycle();
        hcount_in = 11'd673; cycle();
        check("pix_centre", {red_out, green_out, blue_out}, 24'hFFFFFF);
        hcount_in = 11'd672; cycle();
        check("pix_outside_673", {red_out, green_out, blue_out}, 24'h000000);
        hcount_in = 11'd0; cycle();
        check("pix_edge_672", {red_out, green_out, blue_out}, 24'hFFFFFF);

        // Smoothing toward 328, then convergence by unit steps and hold
        pulse_freq(16'd400);
        frame(); check("smooth_1", ball_y, 253 - R);
        frame(); check("smooth_2", ball_y, 271 - R);
        frame(); check("smooth_3", ball_y, 285 - R);
        for (int i = 0; i < 17; i++) frame();
        check("converged", ball_y, 328 - R);
        frame(); frame();
        check("holds", ball_y, 328 - R);

        // Same-cycle sample and frame: pos uses the old target
        freq_in = 16'd0; freq_valid_in = 1'b1; new_frame_in = 1'b1;
        cycle();
        freq_valid_in = 1'b0; new_frame_in = 1'b0;
        cycle();
        check("simul_old_target", ball_y, 328 - R);
        frame();
        check("simul_new_target", ball_y, 303 - R);

        // Colour modes with color_freq = 8'h10
        pulse_freq(16'h0010);
        frame();
        vcount_in = 10'(m_pos);
        hcount_in = 11'd656; color_mode_in = 2'd1; cycle();
        hcount_in = 11'd671; color_mode_in = 2'd2; cycle();
        check("mode1_centre", {red_out, green_out, blue_out}, 24'h1060B0);
        hcount_in = 11'd656; color_mode_in = 2'd3; cycle();
        check("mode2_ring", {red_out, green_out, blue_out}, 24'h083058);
        cycle();
        check("mode3_fixed", {red_out, green_out, blue_out}, 24'hFFFFFF);

        // Clamp at Y_MAX
        pulse_freq(16'hFFFF);
        for (int i = 0; i < 40; i++) begin
            frame();
            check("clamp_bound", ball_y <= 10'(YM - R), 1'b1);
        end
        check("clamp_final", ball_y, YM - R);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            freq_valid_in = ($urandom_range(0, 7) == 0);
            freq_in       = 16'($urandom_range(0, 65535));
            new_frame_in  = ($urandom_range(0, 9) == 0);
            color_mode_in = 2'($urandom_range(0, 3));
            hcount_in     = 11'(XC - 20 + $urandom_range(0, 40));
            vcount_in     = 10'(m_pos - 20 + $urandom_range(0, 40));
            cycle();
        end
        freq_valid_in = 1'b0; new_frame_in = 1'b0;
        cycle();

        // Asynchronous reset mid-line
        hcount_in = 11'(XC); vcount_in = 10'(m_pos); color_mode_in = 2'd0;
        cycle(); cycle();
        #3;
        rst_n_in = 1'b0;
        #1;
        check("async_rst_rgb", {red_out, green_out, blue_out}, 24'h0);
        check("async_rst_ball_y", ball_y, 212);
        freq_in = 16'hFFFF; freq_valid_in = 1'b1; new_frame_in = 1'b1;
        @(posedge clk_in); #1;
        @(posedge clk_in); #1;
        check("rst_hold_ball_y", ball_y, 212);
        freq_valid_in = 1'b0; new_frame_in = 1'b0;
        model_reset();
        rst_n_in = 1'b1;
        vcount_in = 10'(YB);
        cycle(); cycle(); cycle();
        frame();
        check("post_rst_pos", ball_y, YB - R);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
